// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default memory geometry and the header range check.
package imem_loader_pkg;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_AW    = 6;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // A word count is usable only if it is non-zero and fits in the memory.
  function automatic logic hdr_ok(input logic [31:0] n, input int depth);
    return (n != 32'd0) && (n <= 32'(depth));
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects accepted bytes into little-endian 32-bit words. The word and its
// strobe are presented during the cycle the fourth byte is accepted, so the
// consumer can act on the same clock edge that takes that byte.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Shift each accepted byte in from the top so the first byte lands in [7:0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (i_en) begin
      r_cnt   <= r_cnt + 2'd1;
      r_shift <= {i_data, r_shift[23:8]};
    end
  end

  assign o_word       = {i_data, r_shift};
  assign o_word_valid = i_en && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader for a small instruction memory: receives a 4-byte word count,
// then that many little-endian program words, and releases the processor
// from reset once the memory is filled. In RUN the memory is read
// combinationally by the processor's program counter.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          cpu_reset,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  state_t      r_state;
  logic        r_in_ready;
  logic        r_cpu_reset;
  logic        r_done;
  logic        r_err;
  logic [AW:0] r_words;
  logic [AW:0] r_n;

  logic [31:0] r_mem [DEPTH];

  logic        w_accept;
  logic [31:0] w_word;
  logic        w_word_valid;
  logic [AW:0] w_words_inc;
  logic        w_mem_we;
  logic [AW-1:0] w_rd_addr;
  logic        w_unused_pc;

  assign w_accept    = in_valid & r_in_ready;
  assign w_words_inc = r_words + (AW+1)'(1);
  assign w_mem_we    = (r_state == ST_LOAD) && w_word_valid;
  assign w_rd_addr   = pc[AW+1:2];
  // Byte offset and bits above the memory span do not select a word.
  assign w_unused_pc = ^{pc[31:AW+2], pc[1:0]};

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_en         (w_accept),
    .i_data       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // Program words are written in arrival order; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_words[AW-1:0]] <= w_word;
    end
  end

  // Loader sequencing with registered handshake and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HDR;
      r_in_ready  <= 1'b1;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_words     <= '0;
      r_n         <= '0;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_word_valid) begin
            if (hdr_ok(w_word, DEPTH)) begin
              r_state <= ST_LOAD;
              r_n     <= w_word[AW:0];
            end else begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_err      <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_word_valid) begin
            r_words <= w_words_inc;
            if (w_words_inc == r_n) begin
              r_state     <= ST_RUN;
              r_in_ready  <= 1'b0;
              r_cpu_reset <= 1'b0;
              r_done      <= 1'b1;
            end
          end
        end
        default: begin
          // RUN and ERR are terminal until the next reset.
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words;
  assign instr        = r_done ? r_mem[w_rd_addr] : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver parses each byte stream with a
// reference model, queues expected events and output snapshots, and a
// negedge monitor pops and compares them as the DUT produces them.
module tb_imem_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  localparam int K_WL   = 0;
  localparam int K_DONE = 1;
  localparam int K_ERR  = 2;

  localparam int P_HDR  = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_ERR  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_ready;
  logic [31:0]   pc = 32'd0;
  logic [31:0]   instr;
  logic          cpu_reset;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .pc           (pc),
    .instr        (instr),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  typedef struct {
    int          tag;
    logic        rdy;
    logic        cpu;
    logic        dn;
    logic        er;
    int          wl;
    logic [31:0] ins;
  } snap_t;

  ev_t   evq[$];
  snap_t snapq[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en = 1'b0;
  bit final_req = 1'b0;
  bit final_done = 1'b0;

  // Reference model state
  int          m_phase = P_HDR;
  int          m_wl = 0;
  int          m_n = 0;
  logic [31:0] m_mem [DEPTH];

  // ---------------- monitor ----------------
  logic [AW:0] p_wl;
  logic        p_done;
  logic        p_err;

  function automatic void check_event(input int kind, input int val);
    ev_t e;
    n_tests++;
    if (evq.size() == 0) begin
      n_fail++;
      $display("FAIL event: actual kind=%0d val=%0d, required no event", kind, val);
      return;
    end
    e = evq.pop_front();
    if (e.kind != kind || e.val != val) begin
      n_fail++;
      $display("FAIL event: actual kind=%0d val=%0d, required kind=%0d val=%0d",
               kind, val, e.kind, e.val);
    end
  endfunction

  function automatic void cmp(input string name, input int tag,
                              input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (tag %0d): actual 0x%0h required 0x%0h", name, tag, act, exp);
    end
  endfunction

  function automatic void check_snap(input snap_t s);
    cmp("in_ready",     s.tag, {31'd0, in_ready},  {31'd0, s.rdy});
    cmp("cpu_reset",    s.tag, {31'd0, cpu_reset}, {31'd0, s.cpu});
    cmp("done",         s.tag, {31'd0, done},      {31'd0, s.dn});
    cmp("err",          s.tag, {31'd0, err},       {31'd0, s.er});
    cmp("words_loaded", s.tag, {25'd0, words_loaded}, 32'(s.wl));
    cmp("instr",        s.tag, instr,              s.ins);
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (words_loaded !== p_wl) check_event(K_WL, int'(words_loaded));
        if (done === 1'b1 && p_done !== 1'b1) check_event(K_DONE, 1);
        if (err === 1'b1 && p_err !== 1'b1) check_event(K_ERR, 1);
        if (snapq.size() > 0) check_snap(snapq.pop_front());
        if (final_req && !final_done) begin
          n_tests++;
          if (evq.size() != 0 || snapq.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: actual %0d events %0d snapshots pending, required 0",
                     evq.size(), snapq.size());
          end
          final_done = 1'b1;
        end
      end
      p_wl   = words_loaded;
      p_done = done;
      p_err  = err;
    end
  end

  // ---------------- reference model ----------------
  // Interprets a byte stream as header + words and queues the events the
  // loader must produce for it; bytes past the end of the load are ignored.
  function automatic void parse(input logic [7:0] s[$]);
    logic [31:0] n;
    logic [31:0] w;
    if (s.size() < 4) return;
    n = {s[3], s[2], s[1], s[0]};
    if (n == 32'd0 || n > 32'(DEPTH)) begin
      m_phase = P_ERR;
      evq.push_back('{K_ERR, 1});
      return;
    end
    m_phase = P_LOAD;
    m_n = int'(n);
    for (int k = 0; k < m_n; k++) begin
      if (s.size() < 8 + 4 * k) break;
      w = {s[7 + 4 * k], s[6 + 4 * k], s[5 + 4 * k], s[4 + 4 * k]};
      m_mem[k] = w;
      m_wl = k + 1;
      evq.push_back('{K_WL, k + 1});
      if (k == m_n - 1) begin
        m_phase = P_RUN;
        evq.push_back('{K_DONE, 1});
      end
    end
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_snap(input int tag, input logic rdy, input logic cpu,
                           input logic dn, input logic er, input int wl,
                           input logic [31:0] ins);
    snapq.push_back('{tag, rdy, cpu, dn, er, wl, ins});
    tick();
  endtask

  task automatic push_model_snap(input int tag);
    logic [31:0] ins;
    ins = 32'd0;
    if (m_phase == P_RUN) ins = m_mem[pc[AW+1:2]];
    push_snap(tag, (m_phase == P_HDR) || (m_phase == P_LOAD), m_phase != P_RUN,
              m_phase == P_RUN, m_phase == P_ERR, m_wl, ins);
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit gaps);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom());
        tick();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    tick();
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gaps);
    foreach (s[i]) drive_byte(s[i], gaps);
    in_valid = 1'b0;
  endtask

  task automatic make_stream(input logic [31:0] n, input int nw, output logic [7:0] q[$]);
    logic [31:0] w;
    q = {};
    for (int i = 0; i < 4; i++) q.push_back(n[8*i +: 8]);
    for (int k = 0; k < nw; k++) begin
      w = $urandom();
      for (int i = 0; i < 4; i++) q.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (evq.size() != 0 && i < 400) begin
      tick();
      i++;
    end
    tick();
  endtask

  task automatic do_reset(input int tag);
    if (m_wl != 0) evq.push_back('{K_WL, 0});
    reset    = 1'b1;
    in_valid = 1'b0;
    pc       = 32'd0;
    m_phase  = P_HDR;
    m_wl     = 0;
    m_n      = 0;
    push_model_snap(tag);
    reset = 1'b0;
    tick();
    push_model_snap(tag + 1);
  endtask

  task automatic read_checks(input int cnt, input int tag);
    logic [31:0] r;
    logic [AW-1:0] ix;
    for (int i = 0; i < cnt; i++) begin
      r  = $urandom();
      ix = AW'($urandom_range(0, m_n - 1));
      pc = {r[31:AW+2], ix, r[1:0]};
      push_model_snap(tag);
    end
  endtask

  task automatic full_load(input logic [31:0] n, input int nw, input bit gaps, input int tag);
    logic [7:0] q[$];
    make_stream(n, nw, q);
    parse(q);
    send_stream(q, gaps);
    wait_drain();
    pc = 32'd0;
    push_model_snap(tag);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] q64[$];
    logic [7:0] qx[$];

    #3 reset = 1'b1;
    tick();
    tick();
    mon_en = 1'b1;
    push_model_snap(1);          // held in reset
    reset = 1'b0;
    tick();
    push_model_snap(2);          // HDR, ready after deassertion

    // Two-word load with fixed contents; done only after the 12th byte's edge
    q = {8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h02, 8'h20,
         8'h0C, 8'h00, 8'h03, 8'h20};
    parse(q);
    for (int i = 0; i < 11; i++) drive_byte(q[i], 1'b0);
    in_valid = 1'b1;
    in_data  = q[11];
    push_snap(3, 1'b1, 1'b1, 1'b0, 1'b0, 1, 32'd0);
    in_valid = 1'b0;
    pc = 32'd0;
    push_snap(4, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h20020005);
    pc = 32'd4;
    push_snap(5, 1'b0, 1'b0, 1'b1, 1'b0, 2, 32'h2003000C);
    wait_drain();
    do_reset(6);

    // Bad headers: zero, DEPTH+1, and a value whose low bits alone look valid
    full_load(32'd0, 1, 1'b0, 10);
    do_reset(11);
    full_load(32'd65, 2, 1'b0, 12);
    do_reset(13);
    full_load(32'h01000001, 1, 1'b0, 14);
    do_reset(15);

    // Full-depth load without gaps, then the same stream with random gaps
    make_stream(32'd64, 64, q64);
    parse(q64);
    send_stream(q64, 1'b0);
    wait_drain();
    pc = 32'd0;
    push_model_snap(20);
    read_checks(8, 21);
    do_reset(22);
    parse(q64);
    send_stream(q64, 1'b1);
    wait_drain();
    pc = 32'd0;
    push_model_snap(23);
    read_checks(8, 24);
    do_reset(25);

    // Reset in the middle of word 1, then a fresh load with gaps
    make_stream(32'd3, 3, q);
    q = q[0:9];
    parse(q);
    send_stream(q, 1'b1);
    wait_drain();
    push_model_snap(30);
    do_reset(31);
    full_load(32'd5, 5, 1'b1, 33);
    pc = 32'h00000104;
    push_model_snap(34);
    for (int i = 0; i < 8; i++) qx.push_back(8'($urandom()));
    send_stream(qx, 1'b0);
    push_model_snap(35);
    read_checks(4, 36);
    do_reset(37);

    // Random sizes with random gaps
    for (int t = 0; t < 3; t++) begin
      int n;
      n = $urandom_range(1, DEPTH);
      full_load(32'(n), n, 1'($urandom_range(0, 1)), 40 + 4 * t);
      read_checks(4, 41 + 4 * t);
      do_reset(42 + 4 * t);
    end

    final_req = 1'b1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit instruction words stored (power of 2).
REQ-002 SHALL have parameter AW, default 6, meaning word-address width, equal to log2(DEPTH).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 SHALL have ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream byte valid
- in_data  input  8  upstream program byte
- in_ready  output  1  loader accepts byte this cycle
- pc  input  32  processor program counter
- instr  output  32  instruction fed to processor
- cpu_reset  output  1  holds processor in reset until load completes
- done  output  1  program loaded; processor running
- err  output  1  bad header; load aborted
- words_loaded  output  AW+1  count of words written so far

Function
REQ-005 SHALL implement states HDR (receive 4-byte word count N), LOAD (receive N program words), RUN and ERR.
REQ-006 SHALL accept a byte only on a rising edge with in_valid=1 and in_ready=1.
REQ-007 SHALL drive in_ready=1 in HDR and LOAD and in_ready=0 in RUN and ERR.
REQ-008 SHALL assemble each 4 accepted bytes little-endian: first byte goes to [7:0] and fourth byte goes to [31:24].
REQ-009 SHALL, on the edge accepting the 4th header byte, go to LOAD if 1<=N<=DEPTH and go to ERR otherwise.
REQ-010 SHALL, on the edge accepting the 4th byte of word k (k from 0), write memory[k] and increment words_loaded.
REQ-011 SHALL, on the edge writing word N-1, go to RUN; done=1 and cpu_reset=0 SHALL be visible the following cycle, not the same cycle.
REQ-012 SHALL treat in_valid=0 cycles as stalls, with no change to byte or word counters.
REQ-013 SHALL, in RUN, drive instr = memory[pc[AW+1:2]] combinationally, with zero-cycle read latency.
REQ-014 SHALL ignore pc[31:AW+2] and pc[1:0].
REQ-015 SHALL return undefined contents for addresses >= N.
REQ-016 SHALL drive instr=0 in HDR, LOAD and ERR.
REQ-017 SHALL keep RUN and ERR until reset; further in_valid activity has no effect.
REQ-018 SHALL hold cpu_reset=1 whenever state is not RUN.
REQ-019 SHALL set err=1 only in ERR.
REQ-020 SHALL set done=1 only in RUN.
REQ-021 SHALL compute words_loaded modulo 2^(AW+1); it reaches at most DEPTH, and DEPTH SHALL be accepted without wrap.

Reset
REQ-022 SHALL, on reset assertion at any time, including mid-word or mid-LOAD, immediately set state=HDR, clear the byte and word counters, and set cpu_reset=1, done=0, err=0, words_loaded=0 and instr=0.
REQ-023 SHALL leave memory contents uncleared by reset; a partial load SHALL be discarded only logically.
REQ-024 SHALL drive in_ready=1 on the first edge after reset deassertion.

Structure
REQ-025 SHALL place state encodings (HDR, LOAD, RUN, ERR) and the DEPTH/AW defaults in the shared project package/include used by the processor modules.
REQ-026 SHALL use one sub-module, byte_packer: a 2-bit byte counter plus 24-bit shift register that emits a 32-bit word and a one-cycle word_valid strobe.
REQ-027 SHALL implement memory as a reg array of DEPTH x 32 with a synchronous write port and an asynchronous read port.

Verification
REQ-028 SHALL cover: header 02 00 00 00, then words 0x20020005 and 0x2003000C, in_valid held 1 -> in_ready low after 12th byte, done=1 next cycle, pc=0 gives instr 0x20020005 and pc=4 gives 0x2003000C.
REQ-029 SHALL cover: header N=0 -> err=1 after 4th byte, in_ready=0, cpu_reset stays 1, instr=0.
REQ-030 SHALL cover: header N=65 with DEPTH=64 -> ERR; header N=64 -> LOAD, and words_loaded reaches 64 then done.
REQ-031 SHALL cover: random in_valid gaps, 50% duty -> memory contents and words_loaded identical to the gap-free run.
REQ-032 SHALL cover: reset asserted after 2 bytes of word 1 -> state HDR, words_loaded=0; a fresh full load then completes correctly.
REQ-033 SHALL cover: in RUN, pc=0x00000104 -> instr = memory[1] (upper bits ignored); extra in_valid bytes -> no change.
